count_updown_mod: RTL and testbench

Parametrised successor to the team's 4-bit loadable counter (`count4`). It is a WIDTH-bit synchronous up/down counter with these features:
- programmable modulus and built-in enable prescaler
- run-time mode select: wrap, saturate, one-shot, hold
- terminal-count and wrap flags

It is the general-purpose event/timebase counter for lab-level designs and replaces fixed-width `count4` instances.

---
 rtl/count_pkg.sv | 18 +
 rtl/count_prescaler.sv | 41 ++++
 rtl/count_updown_mod.sv | 104 ++++++++++
 tb/tb_count_updown_mod.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// Shared encodings for the up/down counter family.
package count_pkg;

    // Run-time counting mode, matches the 2-bit mode port encoding.
    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_HOLD    = 2'b11
    } mode_e;

    // One-shot FSM: DONE is left only by load or reset.
    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_e;

endpackage

// File: rtl/count_prescaler.sv
// Enable prescaler: emits a one-cycle tick every PRESCALE enabled cycles.
module count_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // With PRESCALE=1 the counter sits at 0, so tick reduces to en.
    assign tick = en && (cnt_q == LAST);

    // Next prescale count: clear wins, wrap on tick, hold while disabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Prescale count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/count_updown_mod.sv
// Loadable modulo-MODULUS up/down counter with prescaler, mode select and flags.
module count_updown_mod
    import count_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 16,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             up_dn,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             done
);

    localparam logic [WIDTH-1:0] QMAX = WIDTH'(MODULUS - 1);

    logic             tick;
    mode_e            mode_s;
    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d, step_val;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;

    // Load restarts the prescale phase so the first step is PRESCALE cycles later.
    count_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (load),
        .tick  (tick)
    );

    assign mode_s = mode_e'(mode);
    assign tc     = up_dn ? (q_q == QMAX) : (q_q == '0);

    // Only used away from the terminal, so it never leaves 0..MODULUS-1.
    assign step_val = up_dn ? (q_q + WIDTH'(1)) : (q_q - WIDTH'(1));

    // Next counter value, one-shot state and flags; load overrides any step.
    always_comb begin
        q_d     = q_q;
        state_d = state_q;
        wrap_d  = 1'b0;
        done_d  = done_q;
        if (load) begin
            q_d     = (d > QMAX) ? QMAX : d;
            state_d = RUN;
            done_d  = 1'b0;
        end else if (tick && (state_q == RUN)) begin
            unique case (mode_s)
                MODE_WRAP: begin
                    if (tc) begin
                        q_d    = up_dn ? '0 : QMAX;
                        wrap_d = 1'b1;
                    end else begin
                        q_d = step_val;
                    end
                end
                MODE_SAT: begin
                    if (!tc) q_d = step_val;
                end
                MODE_ONESHOT: begin
                    if (tc) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        q_d = step_val;
                    end
                end
                MODE_HOLD: ;
                default: ;
            endcase
        end
    end

    // Counter, FSM and flag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q     <= '0;
            state_q <= RUN;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            q_q     <= q_d;
            state_q <= state_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign q    = q_q;
    assign wrap = wrap_q;
    assign done = done_q;

endmodule

// File: tb/tb_count_updown_mod.sv
// Scoreboard bench for count_updown_mod (WIDTH=4, MODULUS=10; PRESCALE 1 and 3).
module tb_count_updown_mod;

    typedef struct {
        int         sel;
        logic [3:0] q;
        logic       tc;
        logic       wrap;
        logic       done;
        string      name;
    } exp_t;

    logic       clk;
    logic       reset, en, load, up_dn;
    logic [3:0] d;
    logic [1:0] mode;
    logic [3:0] q1, q3;
    logic       tc1, tc3, wrap1, wrap3, done1, done3;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    count_updown_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset), .en(en), .load(load), .d(d), .up_dn(up_dn),
        .mode(mode), .q(q1), .tc(tc1), .wrap(wrap1), .done(done1)
    );

    count_updown_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) dut3 (
        .clk(clk), .reset(reset), .en(en), .load(load), .d(d), .up_dn(up_dn),
        .mode(mode), .q(q3), .tc(tc3), .wrap(wrap3), .done(done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every cycle, just after the edge, compare against the oldest expectation.
    always begin
        exp_t       e;
        logic [6:0] got, want;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e    = sb.pop_front();
            want = {e.q, e.tc, e.wrap, e.done};
            got  = (e.sel == 3) ? {q3, tc3, wrap3, done3} : {q1, tc1, wrap1, done1};
            n_checks++;
            if (got === want) begin
                n_pass++;
            end else begin
                $display("FAIL %s (dut%0d): got q=%0d tc=%b wrap=%b done=%b, want q=%0d tc=%b wrap=%b done=%b",
                         e.name, e.sel, got[6:3], got[2], got[1], got[0],
                         e.q, e.tc, e.wrap, e.done);
            end
        end
    end

    // Clock one edge with the current inputs and queue the expected post-edge outputs.
    task automatic step(input int sel, input logic [3:0] eq, input logic etc,
                        input logic ew, input logic edn, input string nm);
        exp_t e;
        @(posedge clk);
        e.sel  = sel;
        e.q    = eq;
        e.tc   = etc;
        e.wrap = ew;
        e.done = edn;
        e.name = nm;
        sb.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        int qv;
        reset = 1'b0; en = 1'b0; load = 1'b0; up_dn = 1'b1; d = 4'd0; mode = 2'b00;

        // 1: reset, then wrap-mode up count with one wrap pulse
        step(1, 4'd0, 1'b0, 1'b0, 1'b0, "s1_reset");
        step(1, 4'd0, 1'b0, 1'b0, 1'b0, "s1_reset");
        reset = 1'b1; en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            qv = k % 10;
            step(1, 4'(qv), qv == 9, k == 10, 1'b0, "s1_up_wrap");
        end

        // 2: clamped load, down count, wrap on 0->9
        load = 1'b1; d = 4'b1101; up_dn = 1'b0; en = 1'b0;
        step(1, 4'd9, 1'b0, 1'b0, 1'b0, "s2_load_clamp");
        load = 1'b0; en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            qv = (k <= 9) ? 9 - k : 9;
            step(1, 4'(qv), qv == 0, k == 10, 1'b0, "s2_down_wrap");
        end

        // 3: saturate up, then direction flip
        mode = 2'b01; load = 1'b1; d = 4'd7; up_dn = 1'b1; en = 1'b0;
        step(1, 4'd7, 1'b0, 1'b0, 1'b0, "s3_load7");
        load = 1'b0; en = 1'b1;
        step(1, 4'd8, 1'b0, 1'b0, 1'b0, "s3_sat_up");
        step(1, 4'd9, 1'b1, 1'b0, 1'b0, "s3_sat_up");
        step(1, 4'd9, 1'b1, 1'b0, 1'b0, "s3_sat_hold");
        step(1, 4'd9, 1'b1, 1'b0, 1'b0, "s3_sat_hold");
        step(1, 4'd9, 1'b1, 1'b0, 1'b0, "s3_sat_hold");
        up_dn = 1'b0; en = 1'b0;
        step(1, 4'd9, 1'b0, 1'b0, 1'b0, "s3_tc_drop");
        en = 1'b1;
        step(1, 4'd8, 1'b0, 1'b0, 1'b0, "s3_sat_down");

        // 4: one-shot, sticky done across a mode change, cleared by load
        mode = 2'b10; load = 1'b1; d = 4'd7; up_dn = 1'b1; en = 1'b0;
        step(1, 4'd7, 1'b0, 1'b0, 1'b0, "s4_load7");
        load = 1'b0; en = 1'b1;
        step(1, 4'd8, 1'b0, 1'b0, 1'b0, "s4_os_run");
        step(1, 4'd9, 1'b1, 1'b0, 1'b0, "s4_os_run");
        step(1, 4'd9, 1'b1, 1'b0, 1'b1, "s4_os_done");
        step(1, 4'd9, 1'b1, 1'b0, 1'b1, "s4_os_sticky");
        mode = 2'b00;
        step(1, 4'd9, 1'b1, 1'b0, 1'b1, "s4_mode_chg");
        step(1, 4'd9, 1'b1, 1'b0, 1'b1, "s4_mode_chg");
        load = 1'b1; d = 4'd0;
        step(1, 4'd0, 1'b0, 1'b0, 1'b0, "s4_load_clr");
        load = 1'b0;
        step(1, 4'd1, 1'b0, 1'b0, 1'b0, "s4_resume");
        step(1, 4'd2, 1'b0, 1'b0, 1'b0, "s4_resume");

        // 5: reset beats load; load beats a simultaneous step
        reset = 1'b0; load = 1'b1; d = 4'd5;
        step(1, 4'd0, 1'b0, 1'b0, 1'b0, "s5_reset_wins");
        reset = 1'b1;
        step(1, 4'd5, 1'b0, 1'b0, 1'b0, "s5_load_wins");
        load = 1'b0;
        step(1, 4'd6, 1'b0, 1'b0, 1'b0, "s5_after_load");

        // 6: PRESCALE=3 instance
        reset = 1'b0; en = 1'b0; mode = 2'b00; up_dn = 1'b1; d = 4'd0;
        step(3, 4'd0, 1'b0, 1'b0, 1'b0, "s6_reset");
        reset = 1'b1; en = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step(3, 4'(k / 3), 1'b0, 1'b0, 1'b0, "s6_prescale");
        end
        en = 1'b0;
        step(3, 4'd3, 1'b0, 1'b0, 1'b0, "s6_en_low");
        step(3, 4'd3, 1'b0, 1'b0, 1'b0, "s6_en_low");
        en = 1'b1;
        step(3, 4'd3, 1'b0, 1'b0, 1'b0, "s6_delayed");
        step(3, 4'd3, 1'b0, 1'b0, 1'b0, "s6_delayed");
        step(3, 4'd4, 1'b0, 1'b0, 1'b0, "s6_delayed_step");
        mode = 2'b11;
        for (int k = 1; k <= 6; k++) begin
            step(3, 4'd4, 1'b0, 1'b0, 1'b0, "s6_hold");
        end
        mode = 2'b00;
        step(3, 4'd4, 1'b0, 1'b0, 1'b0, "s6_phase");
        step(3, 4'd4, 1'b0, 1'b0, 1'b0, "s6_phase");
        step(3, 4'd5, 1'b0, 1'b0, 1'b0, "s6_phase_step");

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            n_checks++;
            $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
